busca_operandos: RTL and testbench
==================================

# busca_operandos

Operand-fetch unit driving the read and write ports of the 16x16-bit register bank (`banco_registradores`). It accepts decoded register indices through a valid/ready handshake, issues them to the bank's registered read ports, and resolves the bank's one-cycle read latency and its old-value-on-same-edge-write behaviour. Results are delivered as a held, registered output stage, with writeback forwarding and snooping. It sits between decode and execute and owns the bank's write port.

## Interface
- `LARGURA`, 16: data width; must match the bank.
- `NBITS_REG`, 4: register index width (16 registers, all writable, no hardwired zero).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: request valid.
- `in_ready` out 1: request accepted when `in_valid && in_ready` at a rising edge.
- `rs1`, `rs2` in 4: source register indices.
- `rd` in 4: destination index; carried through to the output.
- `wb_valid` in 1: writeback strobe.
- `wb_reg` in 4: writeback register index.
- `wb_dado` in 16: writeback data.
- `entrada1`, `entrada2` out 4: bank read addresses.
- `entrada3` out 4: bank write address.
- `sinal` out 1: bank write enable.
- `dado` out 16: bank write data.
- `saida1`, `saida2` in 16: bank read data, registered in the bank.
- `out_valid` out 1: operands valid.
- `out_ready` in 1: consumer accepts when `out_valid && out_ready` at an edge.
- `op1`, `op2` out 16: operand values.
- `out_rd` out 4: destination index paired with the operands.

## Operation
- Bank write path is combinational:
  - `entrada3 = wb_reg`, `dado = wb_dado`.
  - `sinal = wb_valid && !reset`.
- Bank read addresses are combinational from the request: `entrada1 = rs1`, `entrada2 = rs2`.
- Stage A, the bank-read cycle:
  - On acceptance, set `A_valid <= 1` and capture rs1, rs2 and rd.
  - Also capture the bypass flags `b1 <= wb_valid && wb_reg==rs1` and `b2 <= wb_valid && wb_reg==rs2`, with data `bd1/bd2 <= wb_dado`. This is needed because the bank returns the old value on a same-edge write.
- Stage A operand selection, highest priority first:
  1. Current writeback (`wb_valid && wb_reg==A_rs1`) gives `wb_dado`.
  2. Otherwise, if `b1`, gives `bd1`.
  3. Otherwise gives `saida1`.
  - The same rules apply to op2.
- Stage B, the output registers `op1`, `op2`, `out_rd`, `out_valid`, plus a stored `out_rs1` and `out_rs2`:
  - Loaded from stage A when `A_valid && (!out_valid || out_ready)`.
  - `A_valid` clears on that transfer unless a new request is accepted in the same cycle.
- Snooping while held (`out_valid && !out_ready`):
  - Each edge with `wb_valid && wb_reg==out_rs1` sets `op1 <= wb_dado`. The same applies to op2.
  - If both indices match, both operands update.
- `in_ready = !reset && (!A_valid || !out_valid || out_ready)`.
- `out_valid` clears on consumption when stage A is empty.
- Two writebacks to the same register in consecutive cycles: the latest value wins.

## Timing
- Reset values: `out_valid=0`, `op1=op2=0`, `out_rd=0`, `A_valid=0`, all bypass flags 0.
- During reset: `in_ready=0` and `sinal=0`.
- Reset mid-operation discards both stages on the next edge. Bank contents are not cleared.
- Latency: request accepted at edge N gives `out_valid=1` after edge N+1 when stage B is free.
- Throughput: one request per cycle with `out_ready` held high.
- Stall: with `out_ready=0` and both stages full, `in_ready=0`.
  - Stage A keeps `entrada1/2` driven from its held indices, so the bank re-reads every cycle.
  - Writebacks during the stall go through the stage-A forwarding rule.
- `op1`, `op2` and `out_rd` are stable while `out_valid && !out_ready`, except for snoop updates.

## Test plan
- Reset and write: `reset=1` for 2 cycles, then writeback R3=16'h00A5, then fetch rs1=3, rs2=3, rd=7.
  - Expect `in_ready=0` during reset.
  - Expect op1=op2=16'h00A5 and out_rd=7 two edges after acceptance.
- Same-edge hazard: writeback R5=16'h1234 on the same edge a request with rs1=5 is accepted, where R5 previously held 16'h0001.
  - Expect op1=16'h1234, not 16'h0001.
- Stage-A forward: request with rs2=9 accepted, then writeback R9=16'hBEEF in the next cycle.
  - Expect op2=16'hBEEF.
- Output stall with snoop: hold `out_ready=0` for 4 cycles with op1 from R2, and write R2=16'h7777 in cycle 3.
  - Expect op1 to become 16'h7777.
  - Expect `in_ready=0` once stage A is also full.
  - Expect no request lost after release.
- Back-to-back streaming: 16 requests rs1=i, rs2=15-i with `out_ready=1` and the bank preloaded with Ri=i*16'h0101.
  - Expect one output per cycle in order, with op1=i*16'h0101.
- Reset mid-stream: assert `reset` while both stages are valid.
  - Expect `out_valid=0` next cycle, `sinal=0` during reset, and bank contents retained.

Source files
------------

// File: rtl/busca_operandos.sv
// busca_operandos -- operand-fetch unit between decode and execute.
//
// Drives the register bank's two registered read ports and owns its write
// port. Because the bank returns data one cycle after the address and
// returns the old value on a same-edge write, the unit keeps a stage-A
// record of which writebacks the bank read could not have seen. Operands
// leave through a held output register (stage B) that keeps snooping
// writebacks while the consumer stalls.
//
// Ports:
//   clk, reset            clock (rising edge), synchronous active-high reset
//   in_valid/in_ready     request handshake; rs1, rs2 sources, rd destination
//   wb_valid/wb_reg/wb_dado  writeback strobe, index and data
//   entrada1/entrada2     bank read addresses; saida1/saida2 bank read data
//   entrada3/sinal/dado   bank write address, enable and data
//   out_valid/out_ready   operand handshake; op1, op2, out_rd results
module busca_operandos #(
  parameter int LARGURA   = 16,
  parameter int NBITS_REG = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NBITS_REG-1:0] rs1,
  input  logic [NBITS_REG-1:0] rs2,
  input  logic [NBITS_REG-1:0] rd,
  input  logic                 wb_valid,
  input  logic [NBITS_REG-1:0] wb_reg,
  input  logic [LARGURA-1:0]   wb_dado,
  output logic [NBITS_REG-1:0] entrada1,
  output logic [NBITS_REG-1:0] entrada2,
  output logic [NBITS_REG-1:0] entrada3,
  output logic                 sinal,
  output logic [LARGURA-1:0]   dado,
  input  logic [LARGURA-1:0]   saida1,
  input  logic [LARGURA-1:0]   saida2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LARGURA-1:0]   op1,
  output logic [LARGURA-1:0]   op2,
  output logic [NBITS_REG-1:0] out_rd
);

  // Stage A (bank-read cycle) state
  logic                 vld_p0;
  logic [NBITS_REG-1:0] rs1_p0, rs2_p0, rd_p0;
  logic                 b1_p0, b2_p0;
  logic [LARGURA-1:0]   bd1_p0, bd2_p0;

  // Stage B indices kept for snooping while the output is held
  logic [NBITS_REG-1:0] out_rs1_p1, out_rs2_p1;

  logic                 accept;
  logic                 a_take;
  logic                 a_hold;
  logic                 b_held;
  logic [LARGURA-1:0]   fwd1, fwd2;

  function automatic logic [LARGURA-1:0] sel_operand(
    input logic                 wbv,
    input logic [NBITS_REG-1:0] wbr,
    input logic [LARGURA-1:0]   wbd,
    input logic [NBITS_REG-1:0] idx,
    input logic                 byp,
    input logic [LARGURA-1:0]   bypd,
    input logic [LARGURA-1:0]   bank
  );
    if (wbv && (wbr == idx)) return wbd;
    else if (byp)            return bypd;
    else                     return bank;
  endfunction

  assign entrada3 = wb_reg;
  assign dado     = wb_dado;
  assign sinal    = wb_valid && !reset;

  assign in_ready = !reset && (!vld_p0 || !out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign a_take   = vld_p0 && (!out_valid || out_ready);
  assign a_hold   = vld_p0 && !a_take;
  assign b_held   = out_valid && !out_ready;

  // While stage A is stuck it re-reads its own indices every cycle, so the
  // bank data stays current; otherwise the incoming request is addressed.
  assign entrada1 = a_hold ? rs1_p0 : rs1;
  assign entrada2 = a_hold ? rs2_p0 : rs2;

  assign fwd1 = sel_operand(wb_valid, wb_reg, wb_dado, rs1_p0, b1_p0, bd1_p0, saida1);
  assign fwd2 = sel_operand(wb_valid, wb_reg, wb_dado, rs2_p0, b2_p0, bd2_p0, saida2);

  // ---- Stage A: capture request and the writes the bank read will miss ----
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      b1_p0  <= 1'b0;
      b2_p0  <= 1'b0;
    end else if (accept) begin
      vld_p0 <= 1'b1;
      b1_p0  <= wb_valid && (wb_reg == rs1);
      b2_p0  <= wb_valid && (wb_reg == rs2);
    end else if (a_take) begin
      vld_p0 <= 1'b0;
    end else if (a_hold) begin
      // The re-read at this edge also returns the pre-write value.
      b1_p0  <= wb_valid && (wb_reg == rs1_p0);
      b2_p0  <= wb_valid && (wb_reg == rs2_p0);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      rs1_p0 <= rs1;
      rs2_p0 <= rs2;
      rd_p0  <= rd;
      bd1_p0 <= wb_dado;
      bd2_p0 <= wb_dado;
    end else if (a_hold) begin
      bd1_p0 <= wb_dado;
      bd2_p0 <= wb_dado;
    end
  end

  // ---- Stage B: held output registers with writeback snooping ----
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      op1       <= '0;
      op2       <= '0;
      out_rd    <= '0;
    end else if (a_take) begin
      out_valid <= 1'b1;
      op1       <= fwd1;
      op2       <= fwd2;
      out_rd    <= rd_p0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else if (b_held && wb_valid) begin
      if (wb_reg == out_rs1_p1) op1 <= wb_dado;
      if (wb_reg == out_rs2_p1) op2 <= wb_dado;
    end
  end

  always_ff @(posedge clk) begin
    if (a_take) begin
      out_rs1_p1 <= rs1_p0;
      out_rs2_p1 <= rs2_p0;
    end
  end

endmodule

// File: tb/tb_busca_operandos.sv
module tb_busca_operandos;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  rs1, rs2, rd;
  logic        wb_valid;
  logic [3:0]  wb_reg;
  logic [15:0] wb_dado;
  logic [3:0]  entrada1, entrada2, entrada3;
  logic        sinal;
  logic [15:0] dado;
  logic [15:0] saida1, saida2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] op1, op2;
  logic [3:0]  out_rd;

  always #5 clk = ~clk;

  busca_operandos #(.LARGURA(16), .NBITS_REG(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_dado(wb_dado),
    .entrada1(entrada1), .entrada2(entrada2), .entrada3(entrada3),
    .sinal(sinal), .dado(dado),
    .saida1(saida1), .saida2(saida2),
    .out_valid(out_valid), .out_ready(out_ready),
    .op1(op1), .op2(op2), .out_rd(out_rd)
  );

  // Register bank: registered reads, old value returned on a same-edge write.
  logic [15:0] bank [16];
  always @(posedge clk) begin
    saida1 <= bank[entrada1];
    saida2 <= bank[entrada2];
    if (sinal) bank[entrada3] <= dado;
  end

  // Architectural register state as the bench intends it.
  logic [15:0] ref_mem [16];
  always @(posedge clk)
    if (wb_valid && !reset) ref_mem[wb_reg] <= wb_dado;

  typedef struct {
    logic [3:0] r1;
    logic [3:0] r2;
    logic [3:0] d;
    int         age;
  } req_t;

  req_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   ncyc  = 0;
  logic prev_rst = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // Monitor: the consumer sees, for each request in order, the register
  // contents as they stand when it takes the operands.
  always @(negedge clk) begin
    req_t h;
    ncyc++;
    if (prev_rst) begin
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_op1", 32'(op1), 32'd0);
      chk("rst_op2", 32'(op2), 32'd0);
      chk("rst_out_rd", 32'(out_rd), 32'd0);
    end
    if (reset) begin
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_sinal", 32'(sinal), 32'd0);
      q.delete();
    end else begin
      chk("in_ready", 32'(in_ready), 32'(!(q.size() == 2 && !out_ready)));
      if (q.size() > 0 && (ncyc - q[0].age) >= 2)
        chk("latency", 32'(out_valid), 32'd1);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_output: got out_valid=1 expected no pending request (cycle %0d)", ncyc);
        end else begin
          h = q.pop_front();
          chk("op1", 32'(op1), 32'(ref_mem[h.r1]));
          chk("op2", 32'(op2), 32'(ref_mem[h.r2]));
          chk("out_rd", 32'(out_rd), 32'(h.d));
        end
      end
      if (in_valid && in_ready) q.push_back('{rs1, rs2, rd, ncyc});
    end
    prev_rst = reset;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [3:0] r, input logic [15:0] d);
    wb_valid = 1'b1;
    wb_reg   = r;
    wb_dado  = d;
    cyc();
    wb_valid = 1'b0;
  endtask

  task automatic req(input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
    logic acc;
    logic done;
    done     = 1'b0;
    in_valid = 1'b1;
    rs1      = a;
    rs2      = b;
    rd       = d;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      acc = in_ready;
      cyc();
      if (acc) done = 1'b1;
    end
    in_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no acceptance expected acceptance within 40 cycles");
    end
  endtask

  int t0;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    rs1       = '0;
    rs2       = '0;
    rd        = '0;
    wb_valid  = 1'b0;
    wb_reg    = '0;
    wb_dado   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 16; i++) wb(4'(i), 16'(i * 16'h0101));

    // Reset-and-write scenario.
    wb(4'd3, 16'h00A5);
    req(4'd3, 4'd3, 4'd7);
    repeat (3) cyc();

    // Same-edge hazard: write lands on the acceptance edge.
    wb(4'd5, 16'h0001);
    wb_valid = 1'b1;
    wb_reg   = 4'd5;
    wb_dado  = 16'h1234;
    req(4'd5, 4'd0, 4'd1);
    wb_valid = 1'b0;
    repeat (3) cyc();

    // Write while the request sits in stage A.
    req(4'd4, 4'd9, 4'd2);
    wb(4'd9, 16'hBEEF);
    repeat (3) cyc();

    // Output stall with snoop and stage-A hold forwarding.
    out_ready = 1'b0;
    req(4'd2, 4'd1, 4'd3);
    req(4'd6, 4'd7, 4'd4);
    in_valid = 1'b1;
    rs1 = 4'd8; rs2 = 4'd8; rd = 4'd5;
    cyc();
    wb(4'd6, 16'h6666);
    wb(4'd2, 16'h7777);
    cyc();
    out_ready = 1'b1;
    req(4'd8, 4'd8, 4'd5);
    repeat (4) cyc();

    // Back-to-back streaming.
    for (int i = 0; i < 16; i++) wb(4'(i), 16'(i * 16'h0101));
    t0 = ncyc;
    for (int i = 0; i < 16; i++) req(4'(i), 4'(15 - i), 4'(i));
    chk("throughput_cycles", 32'(ncyc - t0), 32'd16);
    repeat (4) cyc();

    // Reset with both stages full; a write attempted during reset is dropped.
    out_ready = 1'b0;
    req(4'd1, 4'd2, 4'd3);
    req(4'd3, 4'd4, 4'd5);
    reset    = 1'b1;
    wb_valid = 1'b1;
    wb_reg   = 4'd0;
    wb_dado  = 16'hDEAD;
    cyc();
    cyc();
    reset     = 1'b0;
    wb_valid  = 1'b0;
    out_ready = 1'b1;
    req(4'd0, 4'd3, 4'd6);
    repeat (3) cyc();

    // Randomized traffic concentrated on few registers to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      rs1       = 4'($urandom_range(0, 3));
      rs2       = 4'($urandom_range(0, 3));
      rd        = 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      wb_valid  = ($urandom_range(0, 1) != 0);
      wb_reg    = 4'($urandom_range(0, 3));
      wb_dado   = 16'($urandom);
      cyc();
    end
    in_valid  = 1'b0;
    wb_valid  = 1'b0;
    out_ready = 1'b1;

    for (int i = 0; i < 50 && q.size() != 0; i++) cyc();
    chk("drain_pending", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
